// File: rtl/lpc_pkg.sv
// Constants and types shared by the LPC encoder and the LPC synthesis filter.
package lpc_pkg;

  localparam int LPC_ORDER = 10;
  localparam int LPC_FRAC  = 12;
  localparam int ACC_W     = 40;

  localparam logic [15:0] REG_CTRL   = 16'h0000;
  localparam logic [15:0] REG_OVRCNT = 16'h0001;
  localparam logic [15:0] REG_SATCNT = 16'h0002;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_DONE = 2'd2
  } lpc_state_t;

endpackage

// File: rtl/lpc_round_sat.sv
// Round-half-up and saturate a Q.FRAC accumulator down to a DW-bit sample.
module lpc_round_sat
  import lpc_pkg::*;
#(
  parameter int DW   = 16,
  parameter int FRAC = LPC_FRAC
) (
  input  logic signed [ACC_W-1:0] acc,
  output logic signed [DW-1:0]    y,
  output logic                    sat
);

  // One guard bit so adding the half-LSB can never wrap.
  localparam logic signed [ACC_W:0] HALF = {{(ACC_W+1-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
  localparam logic signed [ACC_W:0] MAXV = {{(ACC_W+2-DW){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACC_W:0] MINV = {{(ACC_W+2-DW){1'b1}}, {(DW-1){1'b0}}};

  logic signed [ACC_W:0] rnd;
  logic signed [ACC_W:0] shifted;

  assign rnd     = {acc[ACC_W-1], acc} + HALF;
  assign shifted = rnd >>> FRAC;

  always_comb begin
    y   = shifted[DW-1:0];
    sat = 1'b0;
    if (shifted > MAXV) begin
      y   = MAXV[DW-1:0];
      sat = 1'b1;
    end else if (shifted < MINV) begin
      y   = MINV[DW-1:0];
      sat = 1'b1;
    end
  end

endmodule

// File: rtl/lpc_synth.sv
// LPC synthesis filter y[n] = e[n] - sum A_k*y[n-k], one shared multiplier over the taps.
// state | meaning:  IDLE wait for v | MAC one tap per cycle | DONE round/sat, emit y, shift history
module lpc_synth
  import lpc_pkg::*;
#(
  parameter int DW    = 16,
  parameter int ORDER = LPC_ORDER,
  parameter int FRAC  = LPC_FRAC
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic signed [DW-1:0] e,
  input  logic                 v,
  input  logic signed [DW-1:0] A1,
  input  logic signed [DW-1:0] A2,
  input  logic signed [DW-1:0] A3,
  input  logic signed [DW-1:0] A4,
  input  logic signed [DW-1:0] A5,
  input  logic signed [DW-1:0] A6,
  input  logic signed [DW-1:0] A7,
  input  logic signed [DW-1:0] A8,
  input  logic signed [DW-1:0] A9,
  input  logic signed [DW-1:0] A10,
  input  logic                 coef_load,
  output logic signed [DW-1:0] y,
  output logic                 y_v,
  output logic                 busy,
  input  logic [15:0]          address,
  input  logic                 read,
  input  logic                 write,
  input  logic [15:0]          writedata,
  output logic [15:0]          readdata
);

  localparam int KW = $clog2(ORDER + 1);

  lpc_state_t state, state_nx;
  logic                    start;
  logic [KW-1:0]           k;
  logic signed [ACC_W-1:0] acc, acc_load, prod_ext;
  logic signed [2*DW-1:0]  prod;
  logic signed [DW-1:0]    coef_in [1:ORDER];
  logic signed [DW-1:0]    bank    [1:ORDER];
  logic signed [DW-1:0]    shadow  [1:ORDER];
  logic signed [DW-1:0]    hist    [1:ORDER];
  logic signed [DW-1:0]    rs_y;
  logic                    rs_sat;
  logic                    coef_pend, clr_pend, bypass;
  logic [15:0]             ovrcnt, satcnt;
  logic                    wr_ctrl, wr_ovr, wr_sat, clr_wr, clr_now, ovr_inc, sat_inc;
  logic                    unused_wd;

  always_comb begin
    coef_in[1]  = A1;
    coef_in[2]  = A2;
    coef_in[3]  = A3;
    coef_in[4]  = A4;
    coef_in[5]  = A5;
    coef_in[6]  = A6;
    coef_in[7]  = A7;
    coef_in[8]  = A8;
    coef_in[9]  = A9;
    coef_in[10] = A10;
  end

  assign acc_load = {{(ACC_W-DW-FRAC){e[DW-1]}}, e, {FRAC{1'b0}}};
  assign prod     = bank[k] * hist[k];
  assign prod_ext = {{(ACC_W-2*DW){prod[2*DW-1]}}, prod};
  assign busy     = (state != S_IDLE);

  lpc_round_sat #(.DW(DW), .FRAC(FRAC)) u_round_sat (
    .acc (acc),
    .y   (rs_y),
    .sat (rs_sat)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  // DONE also accepts v so a new sample can start on the edge its predecessor retires.
  always_comb begin
    state_nx = state;
    start    = 1'b0;
    unique case (state)
      S_IDLE: if (v) begin
        start    = 1'b1;
        state_nx = bypass ? S_DONE : S_MAC;
      end
      S_MAC:  if (k == KW'(ORDER)) state_nx = S_DONE;
      S_DONE: begin
        state_nx = S_IDLE;
        if (v) begin
          start    = 1'b1;
          state_nx = bypass ? S_DONE : S_MAC;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign wr_ctrl   = write && (address == REG_CTRL);
  assign wr_ovr    = write && (address == REG_OVRCNT);
  assign wr_sat    = write && (address == REG_SATCNT);
  assign clr_wr    = wr_ctrl && writedata[0];
  assign clr_now   = (clr_wr && (state != S_MAC)) || (clr_pend && (state == S_DONE));
  assign ovr_inc   = v && (state == S_MAC);
  assign sat_inc   = rs_sat && (state == S_DONE);
  assign unused_wd = ^writedata[15:2];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc       <= '0;
      k         <= '0;
      y         <= '0;
      y_v       <= 1'b0;
      coef_pend <= 1'b0;
      clr_pend  <= 1'b0;
      for (int i = 1; i <= ORDER; i++) begin
        bank[i]   <= '0;
        shadow[i] <= '0;
        hist[i]   <= '0;
      end
    end else begin
      y_v <= 1'b0;
      if (start) begin
        acc <= acc_load;
        k   <= KW'(1);
      end else if (state == S_MAC) begin
        acc <= acc - prod_ext;
        k   <= k + 1'b1;
      end

      if (state == S_DONE) begin
        y       <= rs_y;
        y_v     <= 1'b1;
        hist[1] <= rs_y;
        for (int i = 2; i <= ORDER; i++) hist[i] <= hist[i-1];
      end
      if (clr_now) begin
        for (int i = 1; i <= ORDER; i++) hist[i] <= '0;
      end

      // A load during MAC is parked in the shadow bank until the sample retires.
      if (coef_load && (state != S_MAC)) begin
        for (int i = 1; i <= ORDER; i++) bank[i] <= coef_in[i];
      end else if (coef_pend && (state == S_DONE)) begin
        for (int i = 1; i <= ORDER; i++) bank[i] <= shadow[i];
      end
      if (coef_load && (state == S_MAC)) begin
        for (int i = 1; i <= ORDER; i++) shadow[i] <= coef_in[i];
        coef_pend <= 1'b1;
      end else if (state == S_DONE) begin
        coef_pend <= 1'b0;
      end

      if (clr_wr && (state == S_MAC)) clr_pend <= 1'b1;
      else if (state == S_DONE)       clr_pend <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bypass   <= 1'b0;
      ovrcnt   <= '0;
      satcnt   <= '0;
      readdata <= '0;
    end else begin
      if (wr_ctrl) bypass <= writedata[1];

      if (ovr_inc) begin
        if (ovrcnt != 16'hFFFF) ovrcnt <= ovrcnt + 1'b1;
      end else if (wr_ovr) begin
        ovrcnt <= '0;
      end

      if (sat_inc) begin
        if (satcnt != 16'hFFFF) satcnt <= satcnt + 1'b1;
      end else if (wr_sat) begin
        satcnt <= '0;
      end

      if (read) begin
        case (address)
          REG_CTRL:   readdata <= {14'b0, bypass, 1'b0};
          REG_OVRCNT: readdata <= ovrcnt;
          REG_SATCNT: readdata <= satcnt;
          default:    readdata <= '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lpc_synth.sv
// Self-checking bench for lpc_synth: directed vector table, hand sequences, random vs. arithmetic model.
module tb_lpc_synth;
  import lpc_pkg::*;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic signed [15:0] e_i = '0;
  logic               v = 1'b0, coef_load = 1'b0, read = 1'b0, write = 1'b0;
  logic signed [15:0] A [1:10];
  logic [15:0]        address = '0, writedata = '0, readdata;
  logic signed [15:0] y;
  logic               y_v, busy;

  int nchecks = 0;
  int nfail   = 0;
  int mbank [1:10];
  int mhist [1:10];
  int msat  = 0;

  typedef struct {
    bit clr;
    int a1;
    int e;
    int exp_y;
  } vec_t;
  vec_t vt [7];

  always #5 clk = ~clk;

  lpc_synth dut (
    .clk(clk), .rst(rst), .e(e_i), .v(v),
    .A1(A[1]), .A2(A[2]), .A3(A[3]), .A4(A[4]), .A5(A[5]),
    .A6(A[6]), .A7(A[7]), .A8(A[8]), .A9(A[9]), .A10(A[10]),
    .coef_load(coef_load), .y(y), .y_v(y_v), .busy(busy),
    .address(address), .read(read), .write(write),
    .writedata(writedata), .readdata(readdata)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    nchecks++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Filter equation evaluated directly with wide integers.
  task automatic model_step(input int ee, input bit byp, output int yy);
    longint acc;
    acc = longint'(ee) * 4096;
    if (!byp)
      for (int i = 1; i <= 10; i++) acc -= longint'(mbank[i]) * longint'(mhist[i]);
    acc = (acc + 2048) >>> 12;
    if (acc > 32767) begin
      yy = 32767;
      msat++;
    end else if (acc < -32768) begin
      yy = -32768;
      msat++;
    end else begin
      yy = int'(acc);
    end
    for (int i = 10; i > 1; i--) mhist[i] = mhist[i-1];
    mhist[1] = yy;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    address = a; writedata = d; write = 1'b1;
    step();
    write = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, output logic [15:0] d);
    address = a; read = 1'b1;
    step();
    read = 1'b0;
    d = readdata;
  endtask

  task automatic clear_hist();
    wr(REG_CTRL, 16'h0001);
    for (int i = 1; i <= 10; i++) mhist[i] = 0;
  endtask

  task automatic set_coef();
    coef_load = 1'b1;
    step();
    coef_load = 1'b0;
    for (int i = 1; i <= 10; i++) mbank[i] = A[i];
  endtask

  task automatic send(input int ee);
    e_i = 16'(ee); v = 1'b1;
    step();
    v = 1'b0;
  endtask

  task automatic wait_yv(output int n);
    n = 0;
    while (y_v !== 1'b1 && n < 30) begin
      step();
      n++;
    end
  endtask

  task automatic run_sample(input int ee, input int exp_y, input int lat, input string name);
    int n;
    send(ee);
    wait_yv(n);
    chk({name, " latency"}, n, lat);
    chk({name, " y"}, y, exp_y);
    step();
    chk({name, " y_v one cycle"}, y_v, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, yy, cnt;
    logic [15:0] d;

    for (int i = 1; i <= 10; i++) begin
      A[i] = '0; mbank[i] = 0; mhist[i] = 0;
    end
    vt[0] = '{1'b1, -2048, 4096, 4096};
    vt[1] = '{1'b0, -2048, 0, 2048};
    vt[2] = '{1'b0, -2048, 0, 1024};
    vt[3] = '{1'b0, -2048, 0, 512};
    vt[4] = '{1'b0, -2048, 0, 256};
    vt[5] = '{1'b1, -4096, 20000, 20000};
    vt[6] = '{1'b0, -4096, 20000, 32767};

    #3;
    chk("reset y", y, 0);
    chk("reset y_v", y_v, 0);
    chk("reset busy", busy, 0);
    chk("reset readdata", readdata, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    step();

    // Zero bank, single sample: pass-through with 11-cycle latency.
    send(1000);
    chk("busy after T0", busy, 1);
    wait_yv(n);
    chk("first latency", n, 11);
    chk("first y", y, 1000);
    chk("busy after T11", busy, 0);
    step();
    chk("first y_v one cycle", y_v, 0);
    model_step(1000, 1'b0, yy);
    rd(REG_SATCNT, d);
    chk("satcnt after first", d, 0);

    // Impulse response and saturation table.
    for (int i = 0; i < 7; i++) begin
      if (vt[i].clr) clear_hist();
      if (i == 0 || vt[i].a1 != vt[i-1].a1) begin
        A[1] = 16'(vt[i].a1);
        set_coef();
      end
      run_sample(vt[i].e, vt[i].exp_y, 11, $sformatf("vec%0d", i));
      model_step(vt[i].e, 1'b0, yy);
    end
    rd(REG_SATCNT, d);
    chk("satcnt after clamp", d, 1);
    wr(REG_SATCNT, 16'h0000);
    msat = 0;
    rd(REG_SATCNT, d);
    chk("satcnt cleared", d, 0);

    // Overrun plus coef_load during MAC.
    clear_hist();
    A[1] = '0;
    set_coef();
    send(1000);
    repeat (4) step();
    e_i = 16'sd777; v = 1'b1; A[1] = -16'sd2048; coef_load = 1'b1;
    step();
    v = 1'b0; coef_load = 1'b0;
    wait_yv(n);
    chk("overrun latency", n, 6);
    chk("overrun y old bank", y, 1000);
    step();
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (y_v === 1'b1) cnt++;
      step();
    end
    chk("overrun extra y_v", cnt, 0);
    model_step(1000, 1'b0, yy);
    for (int i = 1; i <= 10; i++) mbank[i] = A[i];
    rd(REG_OVRCNT, d);
    chk("ovrcnt", d, 1);
    run_sample(0, 500, 11, "new bank");
    model_step(0, 1'b0, yy);
    wr(REG_OVRCNT, 16'h0000);
    rd(REG_OVRCNT, d);
    chk("ovrcnt cleared", d, 0);

    // Reset at T6 drops the in-flight sample.
    send(1000);
    repeat (6) step();
    rst = 1'b0;
    #1;
    chk("midreset busy", busy, 0);
    chk("midreset y", y, 0);
    chk("midreset y_v", y_v, 0);
    step();
    rst = 1'b1;
    cnt = 0;
    for (int i = 0; i < 15; i++) begin
      if (y_v === 1'b1) cnt++;
      step();
    end
    chk("midreset no y_v", cnt, 0);
    for (int i = 1; i <= 10; i++) begin
      A[i] = '0; mbank[i] = 0; mhist[i] = 0;
    end
    msat = 0;
    run_sample(1000, 1000, 11, "post-reset");
    model_step(1000, 1'b0, yy);

    // CLRHIST in IDLE, then deferred while busy.
    A[1] = -16'sd2048;
    set_coef();
    clear_hist();
    run_sample(4096, 4096, 11, "clr pre");
    model_step(4096, 1'b0, yy);
    clear_hist();
    run_sample(0, 0, 11, "clr idle");
    model_step(0, 1'b0, yy);
    run_sample(4096, 4096, 11, "clr pre2");
    model_step(4096, 1'b0, yy);
    send(8);
    repeat (3) step();
    wr(REG_CTRL, 16'h0001);
    wait_yv(n);
    chk("clr busy latency", n, 7);
    chk("clr busy y", y, 2056);
    step();
    model_step(8, 1'b0, yy);
    for (int i = 1; i <= 10; i++) mhist[i] = 0;
    run_sample(0, 0, 11, "clr deferred");
    model_step(0, 1'b0, yy);

    // BYPASS: one-cycle latency, history still updated.
    wr(REG_CTRL, 16'h0002);
    rd(REG_CTRL, d);
    chk("ctrl readback", d, 2);
    run_sample(-5, -5, 1, "bypass");
    model_step(-5, 1'b1, yy);
    wr(REG_CTRL, 16'h0000);
    model_step(0, 1'b0, yy);
    run_sample(0, yy, 11, "after bypass");
    chk("after bypass rounding", y, -2);

    // Random samples and coefficient sets against the model.
    clear_hist();
    wr(REG_SATCNT, 16'h0000);
    msat = 0;
    for (int s = 0; s < 40; s++) begin
      int ee;
      if (s % 8 == 0) begin
        for (int i = 1; i <= 10; i++) A[i] = 16'($urandom_range(0, 8191)) - 16'sd4096;
        set_coef();
      end
      ee = int'($urandom_range(0, 65535)) - 32768;
      model_step(ee, 1'b0, yy);
      run_sample(ee, yy, 11, $sformatf("rand%0d", s));
    end
    rd(REG_SATCNT, d);
    chk("random satcnt", d, msat);
    rd(16'h0007, d);
    chk("unmapped read", d, 0);

    $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
    $finish;
  end

endmodule
